// File: rtl/comb_bist_pkg.sv
// Shared types and constants for the combinational-block BIST sequencer.
// Imported by the interface, the settle timer and the controller top.
package comb_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  localparam int         VEC_W      = 3;
  localparam int         CNT_W      = 4;
  localparam logic [7:0] EXAMPLE_TT = 8'h31;

endpackage

// File: rtl/comb_bist_ctrl_if.sv
// Control/status and block-under-test bundle of the BIST sequencer.
// master = sequencer side, slave = test-control register + block side.
interface comb_bist_ctrl_if
  import comb_bist_pkg::*;
#(
  parameter int N_IN = VEC_W
);

  logic            start;
  logic            abort;
  logic            y_in;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_count;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_vec;
  logic            err_strobe;

  modport master (
    input  start, abort, y_in,
    output vec_out, busy, done, pass, fail_count,
    output first_fail_valid, first_fail_vec, err_strobe
  );

  modport slave (
    output start, abort, y_in,
    input  vec_out, busy, done, pass, fail_count,
    input  first_fail_valid, first_fail_vec, err_strobe
  );

endinterface

// File: rtl/bist_settle_timer.sv
// Loadable down-counter holding each vector for the settle time.
// Saturates at zero; zero flags that the vector may be sampled.
module bist_settle_timer
  import comb_bist_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/comb_bist_ctrl.sv
// BIST sequencer: walks every input vector of an N-input block,
// waits the settle time, compares y against a truth table.
module comb_bist_ctrl
  import comb_bist_pkg::*;
#(
  parameter int                 N_IN     = VEC_W,
  parameter logic [2**N_IN-1:0] EXPECTED = EXAMPLE_TT,
  parameter int                 SETTLE   = 2
) (
  input logic              clk,
  input logic              reset_n,
  comb_bist_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_t          state, state_n;
  logic [N_IN-1:0] vec, vec_n;
  logic [N_IN:0]   fcnt, fcnt_n;
  logic [N_IN-1:0] ffvec, ffvec_n;
  logic            ffv, ffv_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            pass_q, pass_n;
  logic            err_q, err_n;
  logic            load, en, tmr_zero;

  bist_settle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .en       (en),
    .load_val (RELOAD),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_n = state;
    vec_n   = vec;
    fcnt_n  = fcnt;
    ffvec_n = ffvec;
    ffv_n   = ffv;
    pass_n  = pass_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state)
      IDLE: begin
        vec_n = '0;
        if (bus.start && !bus.abort) begin
          state_n = APPLY;
          load    = 1'b1;
          fcnt_n  = '0;
          ffv_n   = 1'b0;
          ffvec_n = '0;
          pass_n  = 1'b0;
        end
      end
      APPLY: begin
        en = 1'b1;
        if (bus.abort) begin
          state_n = IDLE;
          vec_n   = '0;
          pass_n  = 1'b0;
        end else if (tmr_zero) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        // An aborted CHECK still records its mismatch.
        if (bus.y_in != EXPECTED[vec]) begin
          fcnt_n = fcnt + 1'b1;
          err_n  = 1'b1;
          if (!ffv) begin
            ffv_n   = 1'b1;
            ffvec_n = vec;
          end
        end
        if (bus.abort) begin
          state_n = IDLE;
          vec_n   = '0;
          pass_n  = 1'b0;
        end else if (&vec) begin
          state_n = DONE;
        end else begin
          state_n = APPLY;
          vec_n   = vec + 1'b1;
          load    = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        vec_n   = '0;
        done_n  = 1'b1;
        pass_n  = (fcnt == '0);
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == APPLY) || (state_n == CHECK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      vec    <= '0;
      fcnt   <= '0;
      ffvec  <= '0;
      ffv    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      vec    <= vec_n;
      fcnt   <= fcnt_n;
      ffvec  <= ffvec_n;
      ffv    <= ffv_n;
      busy_q <= busy_n;
      done_q <= done_n;
      pass_q <= pass_n;
      err_q  <= err_n;
    end
  end

  assign bus.vec_out          = vec;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fcnt;
  assign bus.first_fail_valid = ffv;
  assign bus.first_fail_vec   = ffvec;
  assign bus.err_strobe       = err_q;

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Randomized bench for comb_bist_ctrl against a run-level
// reference model of the expected BIST outcome.
module tb_comb_bist_ctrl;
  import comb_bist_pkg::*;

  localparam logic [7:0] TT = 8'h31;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  comb_bist_ctrl_if #(.N_IN(3)) bus ();

  comb_bist_ctrl #(
    .N_IN     (3),
    .EXPECTED (TT),
    .SETTLE   (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Block under test: y = ~b & (a | ~c), plus a fault-injected copy.
  logic       stuck;
  logic [7:0] flip;
  logic       a, b, c, good_y;
  assign {a, b, c} = bus.vec_out;
  assign good_y = ~b & (a | ~c);
  assign bus.y_in = stuck ? 1'b0 : (good_y ^ flip[bus.vec_out]);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {bus.vec_out, bus.busy, bus.done, bus.pass,
            bus.fail_count, bus.first_fail_valid,
            bus.first_fail_vec, bus.err_strobe};
  endfunction

  // Full run: start accepted at edge k, cycle cy follows edge k+cy-1.
  task automatic run(string tag, logic s, logic [7:0] f, bit hold);
    logic [7:0] m;
    int vbad, bbad, ebad, ndone, dcyc, first;
    logic exp_err;
    m = s ? TT : f;
    first = 0;
    for (int v = 7; v >= 0; v--) if (m[v]) first = v;
    vbad = 0; bbad = 0; ebad = 0; ndone = 0; dcyc = 0;
    stuck = s;
    flip = f;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int cy = 1; cy <= 30; cy++) begin
      @(negedge clk);
      if (!hold || cy >= 25) bus.start = 1'b0;
      if (cy <= 24) begin
        if (int'(bus.vec_out) != (cy - 1) / 3) vbad++;
        if (!bus.busy) bbad++;
      end else if (bus.busy) begin
        bbad++;
      end
      exp_err = 1'b0;
      if (cy >= 4 && cy <= 25 && cy % 3 == 1) exp_err = m[(cy - 4) / 3];
      if (bus.err_strobe !== exp_err) ebad++;
      if (bus.done) begin
        ndone++;
        dcyc = cy;
      end
    end
    chk({tag, "_vec_seq"}, vbad, 0);
    chk({tag, "_busy"}, bbad, 0);
    chk({tag, "_err_strobe"}, ebad, 0);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_done_cyc"}, dcyc, 26);
    chk({tag, "_pass"}, bus.pass, (m == 8'h00));
    chk({tag, "_fail_cnt"}, bus.fail_count, $countones(m));
    chk({tag, "_ff_valid"}, bus.first_fail_valid, (m != 8'h00));
    chk({tag, "_ff_vec"}, bus.first_fail_vec, first);
    chk({tag, "_idle_vec"}, bus.vec_out, 0);
  endtask

  initial begin
    int nd, nb;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    stuck = 1'b0;
    flip = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    run("good", 1'b0, 8'h00, 1'b0);
    run("stuck0", 1'b1, 8'h00, 1'b0);
    run("inv6", 1'b0, 8'h40, 1'b0);
    run("hold_start", 1'b0, 8'h00, 1'b1);

    // Abort while vector 3 is applied, after the vector-0 mismatch.
    stuck = 1'b1;
    flip = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_vec", bus.vec_out, 3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_vec", bus.vec_out, 0);
    chk("abort_pass", bus.pass, 0);
    chk("abort_fcnt", bus.fail_count, 1);
    chk("abort_ffv", bus.first_fail_valid, 1);
    chk("abort_ffvec", bus.first_fail_vec, 0);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run("after_abort", 1'b1, 8'h00, 1'b0);

    // start and abort together in IDLE must not start a run.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    nb = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done) nb++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    if (bus.busy) nb++;
    chk("start_abort_idle", nb, 0);

    // Asynchronous reset in the middle of a CHECK cycle.
    stuck = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_fcnt", bus.fail_count, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outs", outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run("post_reset", 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic       rs;
      logic [7:0] rf;
      rs = ($urandom_range(0, 3) == 0);
      rf = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run($sformatf("rand%0d", i), rs, rf, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
